snn_input_loader: RTL and testbench

Front-end loader for the SNN classifier. It accepts the 784-pixel binary image as 98 bytes from the UART receiver and serializes each byte LSB-first into the 1-bit-wide input RAM. It then pulses `start` into `snn_core`, hands the input RAM address port to the core while it runs, and forwards the classified digit as an ASCII byte to the UART transmitter. It is the writer/initiator side of the input-RAM and start/done interface that `snn_core` reads and responds on.

---
 rtl/snn_input_loader_if.sv | 55 +++++
 rtl/snn_input_loader.sv | 165 ++++++++++++++++
 tb/tb_snn_input_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_input_loader_if.sv
// ---------------------------------------------------------------------------
// snn_input_loader_if
//
// Bundles every non-clock, non-reset signal of the SNN input loader:
//   receiver side    : rx_rdy, rx_data (in to loader), clr_rx_rdy (out)
//   input RAM side   : ram_addr, ram_data, ram_we (out)
//   core side        : core_addr, core_done, core_digit (in), core_start (out)
//   transmitter side : tx_busy (in), tx_start, tx_data (out)
//   status           : busy (out)
//
// Modports:
//   master : the loader itself (drives RAM, start and transmit signals)
//   slave  : the surrounding environment (UART RX/TX, RAM, snn_core)
// ---------------------------------------------------------------------------
interface snn_input_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  // UART receiver handshake
  logic                  rx_rdy;
  logic [7:0]            rx_data;
  logic                  clr_rx_rdy;

  // Input RAM write / read-address port
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_data;
  logic                  ram_we;

  // snn_core start/done interface
  logic [ADDR_WIDTH-1:0] core_addr;
  logic                  core_start;
  logic                  core_done;
  logic [3:0]            core_digit;

  // UART transmitter handshake
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_busy;

  // Frame-in-progress status
  logic                  busy;

  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    output clr_rx_rdy, ram_addr, ram_data, ram_we, core_start,
           tx_start, tx_data, busy
  );

  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    input  clr_rx_rdy, ram_addr, ram_data, ram_we, core_start,
           tx_start, tx_data, busy
  );

endinterface

// File: rtl/snn_input_loader.sv
// ---------------------------------------------------------------------------
// snn_input_loader
//
// Front end of the SNN classifier. Receives a binary image as bytes from the
// UART receiver, writes each byte LSB-first into the 1-bit-wide input RAM,
// kicks off snn_core with a single start pulse, lends the RAM address port
// to the core while it runs, and finally sends the classified digit to the
// UART transmitter as an ASCII character ('0' + digit).
//
// Parameters:
//   NUM_BITS   : image bits per frame (multiple of 8)
//   ADDR_WIDTH : input RAM address width (must hold NUM_BITS)
//
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous, active-high reset
//   bus : snn_input_loader_if master view
//         rx_rdy/rx_data/clr_rx_rdy      receiver handshake
//         ram_addr/ram_data/ram_we       input RAM port
//         core_addr/core_start/core_done/core_digit   snn_core handshake
//         tx_start/tx_data/tx_busy       transmitter handshake
//         busy                           frame in progress
// ---------------------------------------------------------------------------
module snn_input_loader #(
  parameter int NUM_BITS   = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  snn_input_loader_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SHIFT,
    S_START,
    S_WAIT,
    S_TX
  } state_t;

  state_t                state_reg,      state_next;
  logic [ADDR_WIDTH-1:0] load_addr_reg,  load_addr_next;
  logic [7:0]            shift_reg,      shift_next;
  logic [2:0]            bit_cnt_reg,    bit_cnt_next;
  logic [7:0]            tx_data_reg,    tx_data_next;
  logic                  clr_rx_rdy_reg, clr_rx_rdy_next;
  logic                  core_start_reg, core_start_next;
  logic                  tx_start_reg,   tx_start_next;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_LOAD;
      load_addr_reg  <= '0;
      shift_reg      <= 8'h00;
      bit_cnt_reg    <= 3'd0;
      tx_data_reg    <= 8'h00;
      clr_rx_rdy_reg <= 1'b0;
      core_start_reg <= 1'b0;
      tx_start_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_addr_reg  <= load_addr_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      tx_data_reg    <= tx_data_next;
      clr_rx_rdy_reg <= clr_rx_rdy_next;
      core_start_reg <= core_start_next;
      tx_start_reg   <= tx_start_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-register logic
  // The three pulse outputs are computed here one cycle early and registered,
  // so each one is high for exactly the cycle after the deciding edge.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    load_addr_next  = load_addr_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    tx_data_next    = tx_data_reg;
    clr_rx_rdy_next = 1'b0;
    core_start_next = 1'b0;
    tx_start_next   = 1'b0;

    case (state_reg)
      S_LOAD: begin
        if (bus.rx_rdy) begin
          shift_next      = bus.rx_data;
          bit_cnt_next    = 3'd0;
          clr_rx_rdy_next = 1'b1;
          state_next      = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // One RAM write per cycle; the address counter runs across byte
        // boundaries so the frame lands at consecutive addresses.
        shift_next     = {1'b0, shift_reg[7:1]};
        load_addr_next = load_addr_reg + ADDR_WIDTH'(1);
        bit_cnt_next   = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          if (load_addr_reg == LAST_ADDR) begin
            core_start_next = 1'b1;
            state_next      = S_START;
          end else begin
            state_next      = S_LOAD;
          end
        end
      end

      S_START: begin
        // Rewind now so the next frame starts at address 0 and busy can
        // drop as soon as the result has been handed to the transmitter.
        load_addr_next = '0;
        state_next     = S_WAIT;
      end

      S_WAIT: begin
        if (bus.core_done) begin
          // Digits 10..15 deliberately map onto ':' .. '?'.
          tx_data_next = 8'h30 + {4'h0, bus.core_digit};
          state_next   = S_TX;
        end
      end

      S_TX: begin
        if (!bus.tx_busy) begin
          tx_start_next = 1'b1;
          state_next    = S_LOAD;
        end
      end

      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // RAM controls decode directly from the state register so an asynchronous
  // reset clears them without waiting for a clock edge.
  // -------------------------------------------------------------------------
  logic core_owns_ram;
  assign core_owns_ram = (state_reg == S_START) || (state_reg == S_WAIT);

  assign bus.ram_addr   = core_owns_ram ? bus.core_addr : load_addr_reg;
  assign bus.ram_we     = (state_reg == S_SHIFT);
  assign bus.ram_data   = (state_reg == S_SHIFT) ? shift_reg[0] : 1'b0;
  assign bus.clr_rx_rdy = clr_rx_rdy_reg;
  assign bus.core_start = core_start_reg;
  assign bus.tx_start   = tx_start_reg;
  assign bus.tx_data    = tx_data_reg;

  // A non-zero address in LOAD means a frame is partially loaded.
  assign bus.busy = (state_reg != S_LOAD) || (load_addr_reg != '0);

endmodule

// File: tb/tb_snn_input_loader.sv
// ---------------------------------------------------------------------------
// tb_snn_input_loader
//
// Self-checking bench for snn_input_loader. Frames of random (and one fixed
// 0xA5) bytes are fed through the receiver handshake; a monitor logs every
// RAM write and pulse, and the log is compared against the bit layout the
// frame bytes imply (bit j of byte i lives at address 8*i+j).
// ---------------------------------------------------------------------------
module tb_snn_input_loader;

  localparam int NUM_BITS = 784;
  localparam int AW       = 10;
  localparam int NBYTES   = NUM_BITS / 8;

  logic clk = 1'b0;
  logic rst;

  snn_input_loader_if #(.ADDR_WIDTH(AW)) bus ();

  snn_input_loader #(
    .NUM_BITS   (NUM_BITS),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // -------------------------------------------------------------------------
  // Monitor: observations of DUT outputs, sampled on the falling edge
  // -------------------------------------------------------------------------
  int          cyc            = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic        wr_data_q[$];
  int          start_cnt      = 0;
  int          txs_cnt        = 0;
  int          clr_cnt        = 0;
  int          last_we_cyc    = -1;
  int          last_start_cyc = -1;
  int          pulse_viol     = 0;
  logic        prev_clr = 1'b0, prev_start = 1'b0, prev_txs = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.ram_we === 1'b1) begin
      wr_addr_q.push_back(bus.ram_addr);
      wr_data_q.push_back(bus.ram_data);
      last_we_cyc = cyc;
    end
    if (bus.core_start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (bus.tx_start === 1'b1)   txs_cnt++;
    if (bus.clr_rx_rdy === 1'b1) clr_cnt++;
    if ((bus.clr_rx_rdy && prev_clr) || (bus.core_start && prev_start) ||
        (bus.tx_start && prev_txs))
      pulse_viol++;
    prev_clr   = bus.clr_rx_rdy;
    prev_start = bus.core_start;
    prev_txs   = bus.tx_start;
  end

  // Hard stop if anything hangs despite the bounded waits below.
  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, %0d compared", compared);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Reference frame and helpers
  // -------------------------------------------------------------------------
  logic [7:0] fr [NBYTES];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clr(output int waited);
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      waited++;
      if (bus.clr_rx_rdy === 1'b1) return;
    end
    check("clr_timeout", bus.clr_rx_rdy, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int idx, output int waited);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    wait_clr(waited);
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'($urandom);
    $display("byte %0d: 0x%02h acknowledged after %0d cycles", idx, b, waited);
  endtask

  // Compare n logged writes starting at log index base against the frame.
  task automatic check_writes(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_addr_q.size()) begin
        check("wr_addr", wr_addr_q[base + i], i);
        check("wr_data", wr_data_q[base + i], fr[i / 8][i % 8]);
      end
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_clr"},       bus.clr_rx_rdy, 0);
    check({tag, "_we"},        bus.ram_we,     0);
    check({tag, "_ram_data"},  bus.ram_data,   0);
    check({tag, "_start"},     bus.core_start, 0);
    check({tag, "_tx_start"},  bus.tx_start,   0);
    check({tag, "_busy"},      bus.busy,       0);
    check({tag, "_ram_addr"},  bus.ram_addr,   0);
    check({tag, "_tx_data"},   bus.tx_data,    0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int         w;
    int         base;
    int         wcnt;
    int         clr0;
    int         txs0;
    int         digit;
    logic [7:0] exp_tx;
    logic [7:0] xbyte;
    logic [AW-1:0] ca;

    rst            = 1'b1;
    bus.rx_rdy     = 1'b0;
    bus.rx_data    = 8'h00;
    bus.core_addr  = 10'h155;
    bus.core_done  = 1'b0;
    bus.core_digit = 4'h0;
    bus.tx_busy    = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // ---- Frame 1: 98 x 0xA5 ------------------------------------------------
    base = wr_addr_q.size();
    for (int i = 0; i < NBYTES; i++) fr[i] = 8'hA5;
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(fr[i], i, w);
      if (i == 0) begin
        check("accept_latency", w, 1);
        check("busy_after_first", bus.busy, 1);
      end
    end
    repeat (12) @(negedge clk);
    check("f1_wr_count", wr_addr_q.size() - base, NUM_BITS);
    check_writes(base, NUM_BITS);
    check("f1_start_cnt", start_cnt, 1);
    check("f1_start_timing", last_start_cyc, last_we_cyc + 1);
    check("wait_busy", bus.busy, 1);

    // Core owns the RAM address port while it runs.
    for (int i = 0; i < 3; i++) begin
      ca = AW'($urandom);
      bus.core_addr = ca;
      #1;
      check("ram_addr_mux", bus.ram_addr, ca);
      @(negedge clk);
    end

    // Byte arriving during WAIT must stay pending.
    xbyte       = 8'($urandom);
    bus.rx_data = xbyte;
    bus.rx_rdy  = 1'b1;
    clr0        = clr_cnt;
    repeat (5) @(negedge clk);
    check("rx_in_wait", clr_cnt, clr0);

    // Result 7 with transmitter busy for 20 cycles.
    digit          = 7;
    exp_tx         = 8'(48 + digit);
    bus.tx_busy    = 1'b1;
    bus.core_done  = 1'b1;
    bus.core_digit = 4'(digit);
    @(negedge clk);
    bus.core_done  = 1'b0;
    bus.core_digit = 4'($urandom);
    check("f1_tx_data", bus.tx_data, exp_tx);
    txs0 = txs_cnt;
    repeat (20) @(negedge clk);
    check("backpressure_tx", txs_cnt, txs0);
    check("backpressure_busy", bus.busy, 1);
    check("rx_in_tx", clr_cnt, clr0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("f1_tx_start", bus.tx_start, 1);
    check("f1_busy_fall", bus.busy, 0);
    check("f1_tx_hold", bus.tx_data, exp_tx);
    $display("result: digit %0d sent as 0x%02h", digit, bus.tx_data);

    // Pending byte is now accepted at address 0.
    base = wr_addr_q.size();
    wait_clr(w);
    bus.rx_rdy = 1'b0;
    check("pending_accept", w, 1);
    check("tx_start_single", bus.tx_start, 0);
    $display("byte 0: 0x%02h (pending) acknowledged after %0d cycles", xbyte, w);

    // ---- Frame 2: 50 bytes, stray core_done, then async reset ------------
    fr[0] = xbyte;
    txs0  = txs_cnt;
    for (int i = 1; i < 50; i++) begin
      fr[i] = 8'($urandom);
      send_byte(fr[i], i, w);
      if (i == 10) begin
        bus.core_done  = 1'b1;
        bus.core_digit = 4'd3;
        @(negedge clk);
        bus.core_done  = 1'b0;
      end
    end
    check_writes(base, 49 * 8);
    check("stray_done_tx", txs_cnt, txs0);
    check("stray_done_data", bus.tx_data, exp_tx);

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_reset("async");
    wcnt = wr_addr_q.size();
    repeat (3) @(negedge clk);
    check("rst_no_writes", wr_addr_q.size(), wcnt);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- Frame 3: full random frame after the reset ----------------------
    base = wr_addr_q.size();
    for (int i = 0; i < NBYTES; i++) fr[i] = 8'($urandom);
    for (int i = 0; i < NBYTES - 1; i++) send_byte(fr[i], i, w);
    repeat (12) @(negedge clk);
    check("no_early_start", start_cnt, 1);
    send_byte(fr[NBYTES - 1], NBYTES - 1, w);
    repeat (12) @(negedge clk);
    check("f3_wr_count", wr_addr_q.size() - base, NUM_BITS);
    check_writes(base, NUM_BITS);
    check("f3_start_cnt", start_cnt, 2);
    check("f3_start_timing", last_start_cyc, last_we_cyc + 1);

    // Out-of-range digit maps onto ':'..'?'.
    digit          = $urandom_range(10, 15);
    exp_tx         = 8'(48 + digit);
    bus.core_done  = 1'b1;
    bus.core_digit = 4'(digit);
    @(negedge clk);
    bus.core_done  = 1'b0;
    check("f3_tx_data", bus.tx_data, exp_tx);
    @(negedge clk);
    check("f3_tx_start", bus.tx_start, 1);
    check("f3_busy_fall", bus.busy, 0);
    $display("result: digit %0d sent as 0x%02h", digit, bus.tx_data);

    repeat (3) @(negedge clk);
    check("pulse_width", pulse_viol, 0);
    check("clr_total", clr_cnt, NBYTES + 50 + NBYTES);
    check("tx_total", txs_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
